// File: rtl/aibcr3_red_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aibcr3_red_pkg
// Purpose  : Shared types and helpers for the AIB redundancy / JTAG
//            clock-select sequencer.
//            - state_e   : sequencer states
//            - is_thermo : legality check for redundancy shift codes
//            - NLANE_DEF : default lane count
// Revision : 1.0  initial release
// ============================================================================
package aibcr3_red_pkg;

    localparam int NLANE_DEF  = 8;

    // Widest lane vector the legality helper accepts. Callers pad any unused
    // upper bits with ones so a narrower thermometer code stays a
    // thermometer code after padding.
    localparam int THERMO_MAX = 64;

    localparam logic [THERMO_MAX-1:0] C_THERMO_ONE = {{(THERMO_MAX-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SWITCH   = 2'd2,
        GATE_ON  = 2'd3
    } state_e;

    // A legal code is ones in the upper bits and zeros in the lower bits
    // (including all zeros). Its complement is then a block of low-order
    // ones, i.e. of the form 2^k - 1, which has no bit in common with
    // itself plus one.
    function automatic logic is_thermo(input logic [THERMO_MAX-1:0] vec);
        logic [THERMO_MAX-1:0] inv;
        inv = ~vec;
        return ((inv & (inv + C_THERMO_ONE)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aibcr3_red_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module   : aibcr3_red_settle_cnt
// Purpose  : Load / decrement-to-zero settle counter. Holds at zero, never
//            wraps.
// Ports    : clk_i       clock
//            rst_i       synchronous active-high reset (count -> 0)
//            load_i      load load_val_i (has priority over dec_i)
//            load_val_i  value to load
//            dec_i       decrement by one when non-zero
//            zero_o      count is zero
// Revision : 1.0  initial release
// ============================================================================
module aibcr3_red_settle_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/aibcr3_red_clksel_seq.sv
`default_nettype none
// ============================================================================
// Module   : aibcr3_red_clksel_seq
// Purpose  : Sequences redundancy shift and JTAG clock-select changes for a
//            bank of AIB clock muxes so that a mux select only moves while the
//            lanes it affects have their clocks gated off.
// Ports    : i_cfg_avmm_clk   config clock
//            i_cfg_avmm_rst   synchronous active-high reset
//            req_valid/ready  request handshake (ready only in IDLE)
//            shift_en_req     requested per-lane shift (thermometer code)
//            jtag_clksel_req  requested JTAG clock select
//            settle_cyc       gate-off / gate-on settle cycles (0 acts as 1)
//            shift_en         registered per-lane mux select
//            jtag_clksel      registered JTAG clock select
//            clk_gate_en      per-lane clock enable (1 = running)
//            busy             sequence in progress
//            done / err       one-cycle completion / rejection pulses
// Revision : 1.0  initial release
// ============================================================================
module aibcr3_red_clksel_seq
    import aibcr3_red_pkg::*;
#(
    parameter int NLANE    = NLANE_DEF,
    parameter int SETTLE_W = 4
) (
    input  logic                i_cfg_avmm_clk,
    input  logic                i_cfg_avmm_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [NLANE-1:0]    shift_en_req,
    input  logic                jtag_clksel_req,
    input  logic [SETTLE_W-1:0] settle_cyc,
    output logic [NLANE-1:0]    shift_en,
    output logic                jtag_clksel,
    output logic [NLANE-1:0]    clk_gate_en,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_e                state_q, state_d;
    logic [NLANE-1:0]      shift_en_q, shift_en_d;
    logic                  jtag_q, jtag_d;
    logic [NLANE-1:0]      gate_q, gate_d;
    logic [NLANE-1:0]      chg_q, chg_d;
    logic [NLANE-1:0]      req_shift_q, req_shift_d;
    logic                  req_jtag_q, req_jtag_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  cnt_load;
    logic                  cnt_dec;
    logic [SETTLE_W-1:0]   cnt_val;
    logic                  cnt_zero;

    logic [THERMO_MAX-1:0] w_pad;
    logic                  w_legal;
    logic [NLANE-1:0]      w_chg;
    logic [SETTLE_W-1:0]   w_settle_m1;

    // The counter holds S-1 so that a phase lasting S cycles ends in the
    // cycle where the count reads zero; this keeps S = 2^SETTLE_W - 1
    // representable.
    aibcr3_red_settle_cnt #(
        .W (SETTLE_W)
    ) u_settle_cnt (
        .clk_i      (i_cfg_avmm_clk),
        .rst_i      (i_cfg_avmm_rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        w_pad            = '1;
        w_pad[NLANE-1:0] = shift_en_req;
    end

    assign w_legal     = is_thermo(w_pad);
    // A JTAG clock takeover moves every lane's launch clock, so all lanes
    // are treated as changed.
    assign w_chg       = (jtag_clksel_req != jtag_q) ? '1 : (shift_en_req ^ shift_en_q);
    assign w_settle_m1 = (settle_cyc == '0) ? '0 : (settle_cyc - SETTLE_W'(1));

    always_ff @(posedge i_cfg_avmm_clk) begin
        if (i_cfg_avmm_rst) begin
            state_q     <= IDLE;
            shift_en_q  <= '0;
            jtag_q      <= 1'b0;
            gate_q      <= '1;
            chg_q       <= '0;
            req_shift_q <= '0;
            req_jtag_q  <= 1'b0;
            settle_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_en_q  <= shift_en_d;
            jtag_q      <= jtag_d;
            gate_q      <= gate_d;
            chg_q       <= chg_d;
            req_shift_q <= req_shift_d;
            req_jtag_q  <= req_jtag_d;
            settle_q    <= settle_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_en_d  = shift_en_q;
        jtag_d      = jtag_q;
        gate_d      = gate_q;
        chg_d       = chg_q;
        req_shift_d = req_shift_q;
        req_jtag_d  = req_jtag_q;
        settle_d    = settle_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_val     = settle_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!w_legal) begin
                        err_d = 1'b1;
                    end else if (w_chg == '0) begin
                        done_d = 1'b1;
                    end else begin
                        chg_d       = w_chg;
                        gate_d      = ~w_chg;
                        req_shift_d = shift_en_req;
                        req_jtag_d  = jtag_clksel_req;
                        settle_d    = w_settle_m1;
                        cnt_load    = 1'b1;
                        cnt_val     = w_settle_m1;
                        state_d     = GATE_OFF;
                    end
                end
            end
            // SWITCH is the edge that leaves GATE_OFF: the selects move on
            // the same edge that starts GATE_ON, so it never occupies a
            // registered cycle of its own.
            GATE_OFF: begin
                gate_d = ~chg_q;
                if (cnt_zero) begin
                    shift_en_d = req_shift_q;
                    jtag_d     = req_jtag_q;
                    cnt_load   = 1'b1;
                    state_d    = GATE_ON;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GATE_ON: begin
                if (cnt_zero) begin
                    gate_d  = '1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                gate_d  = '1;
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign shift_en    = shift_en_q;
    assign jtag_clksel = jtag_q;
    assign clk_gate_en = gate_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aibcr3_red_clksel_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aibcr3_red_clksel_seq
// Purpose  : Self-checking bench for aibcr3_red_clksel_seq. A cycle-indexed
//            reference timeline of expected selects/gates plus a queue of
//            expected done/err pulses are produced from the request rules;
//            a monitor compares the DUT against them every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_aibcr3_red_clksel_seq;

    localparam int NL  = 8;
    localparam int SW  = 4;
    localparam int TSZ = 16384;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [NL-1:0] shift_en_req = '0;
    logic          jtag_clksel_req = 1'b0;
    logic [SW-1:0] settle_cyc = '0;
    logic [NL-1:0] shift_en;
    logic          jtag_clksel;
    logic [NL-1:0] clk_gate_en;
    logic          busy;
    logic          done;
    logic          err;

    aibcr3_red_clksel_seq #(.NLANE(NL), .SETTLE_W(SW)) dut (
        .i_cfg_avmm_clk  (clk),
        .i_cfg_avmm_rst  (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .shift_en_req    (shift_en_req),
        .jtag_clksel_req (jtag_clksel_req),
        .settle_cyc      (settle_cyc),
        .shift_en        (shift_en),
        .jtag_clksel     (jtag_clksel),
        .clk_gate_en     (clk_gate_en),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int cyc;
        bit is_err;
    } exp_t;

    exp_t          sb_q[$];
    logic [NL-1:0] t_gate [TSZ];
    logic [NL-1:0] t_shift[TSZ];
    bit            t_jtag [TSZ];
    bit            t_busy [TSZ];
    int            filled    = 0;
    int            ready_cyc = 0;
    logic [NL-1:0] m_shift   = '0;
    bit            m_jtag    = 1'b0;
    bit            m_last_seq = 1'b0;
    bit            mon_en    = 1'b0;

    function automatic bit m_legal(input logic [NL-1:0] v);
        logic [NL-1:0] t;
        for (int k = 0; k <= NL; k++) begin
            t = '1;
            t = t << k;
            if (v == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic fill_steady(input int upto);
        for (int c = filled + 1; c <= upto; c++) begin
            t_gate[c % TSZ]  = '1;
            t_shift[c % TSZ] = m_shift;
            t_jtag[c % TSZ]  = m_jtag;
            t_busy[c % TSZ]  = 1'b0;
        end
        if (upto > filled) filled = upto;
    endtask

    task automatic model_accept(input int c0, input logic [NL-1:0] s, input bit j,
                                input logic [SW-1:0] st);
        int            sdur;
        logic [NL-1:0] chg;
        sdur = (st == 0) ? 1 : int'(st);
        fill_steady(c0);
        if (!m_legal(s)) begin
            sb_q.push_back('{cyc: c0 + 1, is_err: 1'b1});
            ready_cyc  = c0 + 1;
            m_last_seq = 1'b0;
        end else if (s == m_shift && j == m_jtag) begin
            sb_q.push_back('{cyc: c0 + 1, is_err: 1'b0});
            ready_cyc  = c0 + 1;
            m_last_seq = 1'b0;
        end else begin
            chg = (j != m_jtag) ? '1 : (s ^ m_shift);
            for (int k = 1; k <= 2 * sdur; k++) begin
                t_gate[(c0 + k) % TSZ]  = ~chg;
                t_shift[(c0 + k) % TSZ] = (k >= 1 + sdur) ? s : m_shift;
                t_jtag[(c0 + k) % TSZ]  = (k >= 1 + sdur) ? j : m_jtag;
                t_busy[(c0 + k) % TSZ]  = 1'b1;
            end
            sb_q.push_back('{cyc: c0 + 2 * sdur + 1, is_err: 1'b0});
            m_shift    = s;
            m_jtag     = j;
            filled     = c0 + 2 * sdur;
            ready_cyc  = c0 + 2 * sdur + 1;
            m_last_seq = 1'b1;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            logic [NL-1:0] e_gate, e_shift;
            bit            e_jtag, e_busy;
            exp_t          e;
            if (cyc <= filled) begin
                e_gate  = t_gate[cyc % TSZ];
                e_shift = t_shift[cyc % TSZ];
                e_jtag  = t_jtag[cyc % TSZ];
                e_busy  = t_busy[cyc % TSZ];
            end else begin
                e_gate  = '1;
                e_shift = m_shift;
                e_jtag  = m_jtag;
                e_busy  = 1'b0;
            end
            chk("clk_gate_en", 32'(clk_gate_en), 32'(e_gate));
            chk("shift_en", 32'(shift_en), 32'(e_shift));
            chk("jtag_clksel", 32'(jtag_clksel), 32'(e_jtag));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("req_ready", 32'(req_ready), 32'(!e_busy));
            if (done && err) chk("done_err_exclusive", 32'(1), 32'(0));
            if (done || err) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pulse_is_err", 32'(err), 32'(e.is_err));
                end
            end else if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                chk("missing_pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [NL-1:0] s, input bit j, input logic [SW-1:0] st,
                         input int early);
        int eff;
        eff = m_last_seq ? early : 0;
        while (cyc + eff < ready_cyc) begin
            @(posedge clk); #2;
        end
        req_valid       = 1'b1;
        shift_en_req    = s;
        jtag_clksel_req = j;
        settle_cyc      = st;
        while (cyc < ready_cyc) begin
            @(posedge clk); #2;
        end
        model_accept(cyc, s, j, st);
        @(posedge clk); #2;
        // Scramble the request fields after acceptance; they must be ignored.
        req_valid       = 1'b0;
        shift_en_req    = NL'($urandom);
        jtag_clksel_req = 1'($urandom);
        settle_cyc      = SW'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL-1:0] rs;
        bit            seen_done;

        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_shift_en", 32'(shift_en), 32'h0);
        chk("rst_jtag_clksel", 32'(jtag_clksel), 32'h0);
        chk("rst_clk_gate_en", 32'(clk_gate_en), 32'hFF);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'h0);
        @(posedge clk); #2;
        rst       = 1'b0;
        filled    = cyc - 1;
        ready_cyc = cyc;
        mon_en    = 1'b1;

        // Directed cases from the block description.
        issue(8'hF0, 1'b0, 4'd3, 0);   // gate 0F cycles 1-6, shift at 4, done 7
        issue(8'hF0, 1'b1, 4'd0, 0);   // JTAG takeover, all lanes, S treated as 1
        issue(8'h5A, 1'b0, 4'd2, 0);   // illegal code -> err
        issue(8'hF0, 1'b1, 4'd5, 0);   // equal to current -> immediate done
        issue(8'h00, 1'b0, 4'd4, 0);
        issue(8'hC0, 1'b0, 4'd2, 4);   // held during busy, accepted only in IDLE
        issue(8'hFF, 1'b0, 4'd15, 0);  // maximum settle

        // Randomized requests.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                rs = '1;
                rs = rs << $urandom_range(0, NL);
            end else begin
                rs = NL'($urandom);
            end
            issue(rs, 1'($urandom_range(0, 1)), SW'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        // Drain outstanding pulses.
        for (int w = 0; w < 100 && sb_q.size() != 0; w++) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        while (cyc < ready_cyc) begin
            @(posedge clk); #2;
        end

        // Reset in the middle of GATE_OFF.
        mon_en          = 1'b0;
        req_valid       = 1'b1;
        shift_en_req    = m_shift;
        jtag_clksel_req = ~m_jtag;
        settle_cyc      = 4'd5;
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_gated", 32'(clk_gate_en), 32'h00);
        chk("midrst_busy", 32'(busy), 32'h1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_shift_en", 32'(shift_en), 32'h0);
        chk("midrst_jtag", 32'(jtag_clksel), 32'h0);
        chk("midrst_gate", 32'(clk_gate_en), 32'hFF);
        chk("midrst_ready_busy", {30'd0, req_ready, busy}, 32'h2);
        seen_done = done | err;
        repeat (15) begin
            @(negedge clk);
            seen_done = seen_done | done | err;
        end
        chk("midrst_no_done", 32'(seen_done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
